// File: rtl/core_intc.sv
// core_intc: edge-latching interrupt controller in front of the core exception unit.
// Synchronises sources, prioritises masked pendings and runs the irq/ack/eoi handshake.
module core_intc #(
  parameter int NUM_SRC = 8,
  parameter int SYNC_FF = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               eoi,
  input  logic               reg_sel,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_FF];
  logic [NUM_SRC-1:0] sync_d [SYNC_FF];
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] raw;
  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] active_nx;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               wr_mask;
  logic               wr_pend;
  logic               ack_take;

  always_comb begin
    sync_d[0] = src;
    for (int i = 1; i < SYNC_FF; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign raw    = sync_q[SYNC_FF-1];
  assign prev_d = raw;
  assign edges  = raw & ~prev_q;
  assign active = pend_q & mask_q;

  // Lowest index wins: scan downwards so the last hit is the smallest set bit.
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_id    = ID_W'(i);
        win_valid = 1'b1;
      end
    end
  end

  assign wr_mask  = reg_sel && reg_we && (reg_addr == 2'd0);
  assign wr_pend  = reg_sel && reg_we && (reg_addr == 2'd1);
  assign ack_take = (state_q == REQ) && irq_ack && win_valid;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack_take && (win_id == ID_W'(i));
    end
  end

  // A freshly detected edge always beats a W1C or an ack clearing the same bit.
  always_comb begin
    mask_d    = wr_mask ? reg_wdata[NUM_SRC-1:0] : mask_q;
    w1c       = wr_pend ? reg_wdata[NUM_SRC-1:0] : '0;
    pend_d    = (pend_q & ~w1c & ~ack_clr) | edges;
    active_nx = pend_d & mask_d;
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_take) begin
          cur_id_d = win_id;
          state_d  = SERVICE;
        end else if (!(|active_nx)) begin
          // Request withdrawn by mask or W1C before the core took it.
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    irq_d = (state_d == REQ);
  end

  always_comb begin
    reg_rdata = '0;
    if (reg_sel && !reg_we) begin
      case (reg_addr)
        2'd0: reg_rdata[NUM_SRC-1:0] = mask_q;
        2'd1: reg_rdata[NUM_SRC-1:0] = pend_q;
        2'd2: begin
          reg_rdata[ID_W:1] = cur_id_q;
          reg_rdata[0]      = (state_q == SERVICE);
        end
        default: reg_rdata[NUM_SRC-1:0] = raw;
      endcase
    end
  end

  assign irq = irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_FF; i++) begin
        sync_q[i] <= '0;
      end
      prev_q   <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      cur_id_q <= '0;
      irq_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      for (int i = 0; i < SYNC_FF; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q   <= prev_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      cur_id_q <= cur_id_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_core_intc.sv
// tb_core_intc: directed scenarios plus randomized traffic for core_intc,
// compared cycle by cycle against a behavioural model of the controller.
module tb_core_intc;

  localparam int NUM_SRC = 8;
  localparam int SYNC_FF = 2;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic        irq;
  logic        irqAck = 1'b0;
  logic        eoi = 1'b0;
  logic        regSel = 1'b0;
  logic        regWe = 1'b0;
  logic [1:0]  regAddr = '0;
  logic [31:0] regWdata = '0;
  logic [31:0] regRdata;

  int errors = 0;
  int checks = 0;

  // Behavioural model: registers, phase of the handshake and the sampled history of src.
  logic [7:0] mMask;
  logic [7:0] mPend;
  int         mCurId;
  int         mState;
  logic       mIrq;
  logic [7:0] srcQ[$];

  core_intc #(
    .NUM_SRC(NUM_SRC),
    .SYNC_FF(SYNC_FF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .irq      (irq),
    .irq_ack  (irqAck),
    .eoi      (eoi),
    .reg_sel  (regSel),
    .reg_we   (regWe),
    .reg_addr (regAddr),
    .reg_wdata(regWdata),
    .reg_rdata(regRdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lowestIndex(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] addr);
    case (addr)
      2'd0: return 32'(mMask);
      2'd1: return 32'(mPend);
      2'd2: return 32'((mCurId * 2) + ((mState == M_SVC) ? 1 : 0));
      default: return 32'(srcQ[SYNC_FF-1]);
    endcase
  endfunction

  task automatic modelReset();
    mMask  = '0;
    mPend  = '0;
    mCurId = 0;
    mState = M_IDLE;
    mIrq   = 1'b0;
    srcQ   = {};
    for (int i = 0; i <= SYNC_FF; i++) srcQ.push_back(8'h00);
  endtask

  // Advance the model by one clock using the inputs currently being driven.
  task automatic modelStep();
    logic [7:0] rise, act, newMask, clr, newPend;
    int win, nextState;
    bit took;
    rise    = srcQ[SYNC_FF-1] & ~srcQ[SYNC_FF];
    act     = mPend & mMask;
    win     = lowestIndex(act);
    newMask = (regSel && regWe && regAddr == 2'd0) ? regWdata[7:0] : mMask;
    clr     = (regSel && regWe && regAddr == 2'd1) ? regWdata[7:0] : 8'h00;
    took    = (mState == M_REQ) && irqAck && (win >= 0);
    if (took) clr = clr | 8'(1 << win);
    newPend   = (mPend & ~clr) | rise;
    nextState = mState;
    if (mState == M_IDLE && act != 0) nextState = M_REQ;
    else if (mState == M_REQ) begin
      if (took) begin
        nextState = M_SVC;
        mCurId    = win;
      end else if ((newPend & newMask) == 0) nextState = M_IDLE;
    end else if (mState == M_SVC && eoi) nextState = M_IDLE;
    mState = nextState;
    mMask  = newMask;
    mPend  = newPend;
    mIrq   = (nextState == M_REQ);
    srcQ.push_front(src);
    void'(srcQ.pop_back());
  endtask

  // One clock: model step, edge, then check irq a little after the edge and drop pulses.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
    irqAck = 1'b0;
    eoi    = 1'b0;
    regSel = 1'b0;
    regWe  = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    regSel  = 1'b1;
    regWe   = 1'b0;
    regAddr = addr;
    #1;
    checkOutput(tag, regRdata, exp);
    regSel  = 1'b0;
  endtask

  task automatic readModel(input string tag, input logic [1:0] addr);
    readCheck(tag, addr, modelRead(addr));
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    regSel   = 1'b1;
    regWe    = 1'b1;
    regAddr  = addr;
    regWdata = data;
    applyStimulus();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    modelReset();
    #1 rst = 1'b0;
    #11;
    checkOutput("rstIrq", {31'b0, irq}, 32'h0);
    readCheck("rstMask", 2'd0, 32'h0);
    readCheck("rstPend", 2'd1, 32'h0);
    readCheck("rstStat", 2'd2, 32'h0);
    rst = 1'b1;

    // 1: single source, exact request latency, then ack
    writeReg(2'd0, 32'h01);
    src = 8'h01;
    for (int k = 1; k <= SYNC_FF + 3; k++) begin
      applyStimulus();
      checkOutput("latency", {31'b0, irq}, (k >= SYNC_FF + 2) ? 32'h1 : 32'h0);
    end
    irqAck = 1'b1;
    applyStimulus();
    checkOutput("ackIrq", {31'b0, irq}, 32'h0);
    readCheck("s1Stat", 2'd2, 32'h1);
    readCheck("s1Pend", 2'd1, 32'h0);
    eoi = 1'b1;
    applyStimulus();
    src = 8'h00;
    steps(3);

    // 2: two simultaneous sources, lower index served first
    writeReg(2'd0, 32'hFF);
    src = 8'h24;
    steps(SYNC_FF + 2);
    irqAck = 1'b1;
    applyStimulus();
    readCheck("s2Stat", 2'd2, 32'h5);
    readCheck("s2Pend", 2'd1, 32'h20);
    eoi = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("s2Rereq", {31'b0, irq}, 32'h1);
    irqAck = 1'b1;
    applyStimulus();
    readCheck("s2Stat5", 2'd2, 32'hB);
    eoi = 1'b1;
    src = 8'h00;
    applyStimulus();
    steps(3);

    // 3: masked source stays pending until enabled
    regSel = 1'b1; regWe = 1'b1; regAddr = 2'd0; regWdata = 32'h0;
    #1 checkOutput("wrRdata0", regRdata, 32'h0);
    applyStimulus();
    src = 8'h08;
    steps(SYNC_FF + 3);
    readCheck("s3Pend", 2'd1, 32'h08);
    checkOutput("s3NoIrq", {31'b0, irq}, 32'h0);
    writeReg(2'd0, 32'h08);
    checkOutput("s3Irq1", {31'b0, irq}, 32'h0);
    applyStimulus();
    checkOutput("s3Irq2", {31'b0, irq}, 32'h1);
    irqAck = 1'b1;
    applyStimulus();
    eoi = 1'b1;
    applyStimulus();

    // 4: request withdrawn by W1C
    writeReg(2'd0, 32'h02);
    src = 8'h0A;
    steps(SYNC_FF + 2);
    checkOutput("s4Req", {31'b0, irq}, 32'h1);
    writeReg(2'd1, 32'h02);
    checkOutput("s4Drop", {31'b0, irq}, 32'h0);
    applyStimulus();
    readCheck("s4Stat", 2'd2, 32'h6);

    // 5: spurious ack in service, then edge racing a W1C
    writeReg(2'd0, 32'h12);
    src = 8'h08;
    steps(3);
    src = 8'h0A;
    steps(SYNC_FF + 2);
    irqAck = 1'b1;
    applyStimulus();
    readCheck("s5Stat1", 2'd2, 32'h3);
    src = 8'h1A;
    for (int k = 0; k < SYNC_FF + 2; k++) begin
      irqAck = 1'b1;
      applyStimulus();
      checkOutput("s5Spur", {31'b0, irq}, 32'h0);
    end
    readCheck("s5Stat2", 2'd2, 32'h3);
    readCheck("s5Pend", 2'd1, 32'h10);
    eoi = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("s5Rereq", {31'b0, irq}, 32'h1);
    irqAck = 1'b1;
    applyStimulus();
    src = 8'h0A;
    steps(3);
    src = 8'h1A;
    steps(SYNC_FF);
    writeReg(2'd1, 32'h10);
    readCheck("s5SetWins", 2'd1, 32'h10);

    // 6: asynchronous reset in service
    readCheck("s6InSvc", 2'd2, 32'h9);
    #2 rst = 1'b0;
    modelReset();
    #1;
    checkOutput("s6Irq", {31'b0, irq}, 32'h0);
    readCheck("s6Mask", 2'd0, 32'h0);
    readCheck("s6Pend", 2'd1, 32'h0);
    readCheck("s6Stat", 2'd2, 32'h0);
    rst = 1'b1;
    applyStimulus();
    readCheck("s6Idle", 2'd2, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NUM_SRC; b++) begin
        if ($urandom_range(5) == 0) src[b] = ~src[b];
      end
      irqAck = ($urandom_range(2) == 0);
      eoi    = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0) begin
        regSel   = 1'b1;
        regWe    = 1'b1;
        regAddr  = 2'($urandom_range(3));
        regWdata = $urandom;
      end
      applyStimulus();
      readModel("rndReg", 2'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
